progmem_arbiter: RTL

- Two-master to one-slave read arbiter in front of the program-memory slave: an Avalon-MM-style read port with address/read/readdata/response/waitrequest.
- Lets the CPU instruction-fetch port (m0) and the debug/loader read port (m1) share the single ROM port.
- Latches the winning request, forwards it to the slave, and returns data and waitrequest to the winner only.
- A watchdog aborts a hung slave access with an error response.

---
 rtl/progmem_arb_pkg.sv | 34 +++
 rtl/progmem_arb_timeout.sv | 43 ++++
 rtl/progmem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/progmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// progmem_arb_pkg
//   Shared definitions for the program-memory read arbiter:
//     - FSM state encodings (ST_IDLE / ST_REQ / ST_DONE) and the state_t enum
//     - Avalon-style response codes (RESP_OK / RESP_SLVERR)
//     - watchdog counter width
//     - rr_pick_m1(): round-robin tie-break helper
//   Optional build macro used by the arbiter: PROGMEM_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
package progmem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_DONE = ST_DONE
  } state_t;

  // Returns 1 when master 1 should be granted. On a tie the master that did
  // not win last time gets the grant (last_m1 = 1 means m1 won last).
  function automatic logic rr_pick_m1(input logic req0, input logic req1,
                                      input logic last_m1);
    return req1 & (~req0 | ~last_m1);
  endfunction

endpackage

// File: rtl/progmem_arb_timeout.sv
// -----------------------------------------------------------------------------
// progmem_arb_timeout
//   Watchdog for a single slave access. A 16-bit counter that is cleared when
//   a new access is granted and counts every cycle the access is outstanding.
//   o_expire flags the last permitted cycle (count == TIMEOUT-1), so with the
//   counter cleared at grant the abort lands in the TIMEOUT-th cycle of REQ.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   i_clear   in   restart the count at 0 (takes priority over i_enable)
//   i_enable  in   increment the count this cycle
//   o_expire  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module progmem_arb_timeout
  import progmem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TO_CNT_W'(1);
    end
  end

  assign o_expire = (r_count == TO_LAST);

endmodule

// File: rtl/progmem_arbiter.sv
// -----------------------------------------------------------------------------
// progmem_arbiter
//   Two-master to one-slave read arbiter in front of the program ROM port.
//   m0 is the CPU instruction fetch, m1 the debug/loader read port. The winning
//   request is latched and driven to the slave from registers; the slave's
//   completion (data, response, waitrequest low) is forwarded combinationally
//   to the granted master only. A watchdog aborts a hung access with SLVERR.
//
//   Handshake: a master holds read/address until its waitrequest is low for
//   one cycle; that cycle carries readdata/response. On the slave side s_read
//   is held until s_waitrequest is seen low, then dropped for exactly one
//   DONE cycle so the slave returns waitrequest high before the next access.
//
//   FSM: IDLE -> REQ on grant; REQ -> DONE on ack or timeout;
//        DONE -> REQ on grant, else IDLE. Arbitration runs in IDLE and DONE.
//
//   Build option: define PROGMEM_ARB_FIXED_PRIO_EN for fixed priority (m0 always
//   wins ties, no round-robin state). Default is round-robin.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_address/m0_read         master 0 request
//   m0_readdata/m0_response    master 0 completion data / response
//   m0_waitrequest             master 0 stall (low one cycle per completion)
//   m1_*                       same for master 1
//   s_address/s_read           registered slave request
//   s_readdata/s_response      slave completion data / response
//   s_waitrequest              slave stall
//   o_dbg_state                current FSM state (ST_* encoding)
// -----------------------------------------------------------------------------
module progmem_arbiter
  import progmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic [DATA_W-1:0] m0_readdata,
  output logic [1:0]        m0_response,
  output logic              m0_waitrequest,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [1:0]        m1_response,
  output logic              m1_waitrequest,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic [1:0]        s_response,
  input  logic              s_waitrequest,

  output logic [1:0]        o_dbg_state
);

  state_t            r_state;
  logic              r_gnt_m1;     // 0: m0 owns the access, 1: m1 owns it
  logic              r_s_read;
  logic [ADDR_W-1:0] r_s_address;

  logic w_arb_slot;   // state in which a new grant may be issued
  logic w_req_any;
  logic w_pick_m1;
  logic w_grant;
  logic w_in_req;
  logic w_ack;        // slave completed the access this cycle
  logic w_abort;      // watchdog expired with the slave still stalling
  logic w_finish;
  logic w_expire;

  assign w_req_any  = m0_read | m1_read;
  assign w_arb_slot = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_grant    = w_arb_slot & w_req_any;
  assign w_in_req   = (r_state == S_REQ);
  assign w_ack      = w_in_req & ~s_waitrequest;
  assign w_abort    = w_in_req & s_waitrequest & w_expire;
  assign w_finish   = w_ack | w_abort;

`ifdef PROGMEM_ARB_FIXED_PRIO_EN
  // m0 always wins a tie; m1 only gets the port when m0 is not asking.
  assign w_pick_m1 = m1_read & ~m0_read;
`else
  logic r_rr_last;    // 1: m1 won the last grant (reset so m0 wins first tie)

  assign w_pick_m1 = rr_pick_m1(m0_read, m1_read, r_rr_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
    end else if (w_grant) begin
      r_rr_last <= w_pick_m1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered slave-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt_m1    <= 1'b0;
      r_s_read    <= 1'b0;
      r_s_address <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_req_any) begin
            r_gnt_m1    <= w_pick_m1;
            r_s_address <= w_pick_m1 ? m1_address : m0_address;
            r_s_read    <= 1'b1;
            r_state     <= S_REQ;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        S_REQ: begin
          if (w_finish) begin
            r_s_read <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_s_read <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: restarted at every grant, counts while the access is in REQ
  // ---------------------------------------------------------------------------
  progmem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_grant),
    .i_enable (w_in_req),
    .o_expire (w_expire)
  );

  // ---------------------------------------------------------------------------
  // Master-side return path. Only the granted master ever sees a completion;
  // everyone else holds waitrequest high with zero data/response. An abort
  // returns zero data with SLVERR. A master that dropped read early still
  // receives this pulse; it is simply ignored on its side.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_ret_data;
  logic [1:0]        w_ret_resp;

  assign w_ret_data = w_ack ? s_readdata : '0;
  assign w_ret_resp = w_ack ? s_response : RESP_SLVERR;

  always_comb begin
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m0_response    = RESP_OK;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    m1_response    = RESP_OK;
    if (w_finish) begin
      if (r_gnt_m1) begin
        m1_waitrequest = 1'b0;
        m1_readdata    = w_ret_data;
        m1_response    = w_ret_resp;
      end else begin
        m0_waitrequest = 1'b0;
        m0_readdata    = w_ret_data;
        m0_response    = w_ret_resp;
      end
    end
  end

  assign s_read      = r_s_read;
  assign s_address   = r_s_address;
  assign o_dbg_state = r_state;

endmodule
